// File: rtl/countdown_timer_core.sv
// Kitchen countdown timer core: MM:SS loaded in BCD by button pulses, counted down on
// a 1 Hz strobe, with an alarm phase that times out or is acknowledged by start/clear.
module countdown_timer_core #(
    parameter int ALARM_TICKS = 10
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        tick_1s,
    input  logic        btn_start,
    input  logic        btn_min_inc,
    input  logic        btn_sec_inc,
    input  logic        btn_clear,
    output logic [15:0] value,
    output logic [1:0]  state,
    output logic        running,
    output logic        alarm
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [7:0] ALARM_CNT_LAST = 8'(ALARM_TICKS - 1);

    state_t      state_q, state_d;
    logic [15:0] value_q, value_d;
    logic [7:0]  alarm_cnt_q, alarm_cnt_d;
    logic        running_q, running_d;
    logic        alarm_q, alarm_d;

    // Minutes pair increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_min_inc(input logic [7:0] m);
        logic [7:0] r;
        if (m[3:0] == 4'd9) begin
            if (m[7:4] == 4'd9) r = 8'h00;
            else                r = {m[7:4] + 4'd1, 4'd0};
        end else begin
            r = {m[7:4], m[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Seconds pair increment, 59 wraps to 00 without touching minutes.
    function automatic logic [7:0] bcd_sec_inc(input logic [7:0] s);
        logic [7:0] r;
        if (s == 8'h59)           r = 8'h00;
        else if (s[3:0] == 4'd9)  r = {s[7:4] + 4'd1, 4'd0};
        else                      r = {s[7:4], s[3:0] + 4'd1};
        return r;
    endfunction

    // One-second decrement with digit-wise borrow; caller guarantees v is non-zero.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Next-state logic: one event per cycle, clear > start > tick > min_inc > sec_inc.
    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        alarm_cnt_d = alarm_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_clear) begin
                    value_d = 16'h0000;
                end else if (btn_start) begin
                    if (value_q != 16'h0000) state_d = ST_RUN;
                    else                     state_d = ST_IDLE;
                end else if (btn_min_inc) begin
                    value_d[15:8] = bcd_min_inc(value_q[15:8]);
                end else if (btn_sec_inc) begin
                    value_d[7:0] = bcd_sec_inc(value_q[7:0]);
                end else begin
                    value_d = value_q;
                end
            end
            ST_RUN: begin
                if (btn_clear) begin
                    value_d = 16'h0000;
                    state_d = ST_IDLE;
                end else if (btn_start) begin
                    state_d = ST_PAUSE;
                end else if (tick_1s) begin
                    // A zero value here is unreachable; treat it as already expired.
                    if (value_q == 16'h0000 || bcd_dec(value_q) == 16'h0000) begin
                        value_d     = 16'h0000;
                        state_d     = ST_ALARM;
                        alarm_cnt_d = 8'd0;
                    end else begin
                        value_d = bcd_dec(value_q);
                    end
                end else begin
                    value_d = value_q;
                end
            end
            ST_PAUSE: begin
                if (btn_clear) begin
                    value_d = 16'h0000;
                    state_d = ST_IDLE;
                end else if (btn_start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_ALARM: begin
                value_d = 16'h0000;
                if (btn_clear || btn_start) begin
                    state_d     = ST_IDLE;
                    alarm_cnt_d = 8'd0;
                end else if (tick_1s) begin
                    if (alarm_cnt_q >= ALARM_CNT_LAST) begin
                        state_d     = ST_IDLE;
                        alarm_cnt_d = 8'd0;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + 8'd1;
                    end
                end else begin
                    alarm_cnt_d = alarm_cnt_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                value_d     = 16'h0000;
                alarm_cnt_d = 8'd0;
            end
        endcase
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_ALARM);
    end

    // State, value, alarm counter and status flag registers.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q     <= ST_IDLE;
            value_q     <= 16'h0000;
            alarm_cnt_q <= 8'd0;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            alarm_cnt_q <= alarm_cnt_d;
            running_q   <= running_d;
            alarm_q     <= alarm_d;
        end
    end

    assign value   = value_q;
    assign state   = state_q;
    assign running = running_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Directed bench for countdown_timer_core with ALARM_TICKS=3; expected values hand-computed.
module tb_countdown_timer_core;

    logic        clk = 1'b0;
    logic        reset_p;
    logic        tick_1s, btn_start, btn_min_inc, btn_sec_inc, btn_clear;
    logic [15:0] value;
    logic [1:0]  state;
    logic        running, alarm;
    int          tests = 0;
    int          fails = 0;

    countdown_timer_core #(.ALARM_TICKS(3)) dut (
        .clk(clk), .reset_p(reset_p), .tick_1s(tick_1s), .btn_start(btn_start),
        .btn_min_inc(btn_min_inc), .btn_sec_inc(btn_sec_inc), .btn_clear(btn_clear),
        .value(value), .state(state), .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic step(input logic c, input logic s, input logic t, input logic mi, input logic se);
        @(negedge clk);
        btn_clear = c; btn_start = s; tick_1s = t; btn_min_inc = mi; btn_sec_inc = se;
        @(posedge clk);
        #1;
        btn_clear = 1'b0; btn_start = 1'b0; tick_1s = 1'b0; btn_min_inc = 1'b0; btn_sec_inc = 1'b0;
    endtask

    task automatic repeat_step(input int n, input logic t, input logic mi, input logic se);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, t, mi, se);
    endtask

    task automatic chk(input string tag, input logic [15:0] ev, input logic [1:0] es);
        tests++;
        assert (value === ev) else begin
            fails++;
            $error("FAIL %s value=%h expected=%h", tag, value, ev);
        end
        tests++;
        assert (state === es) else begin
            fails++;
            $error("FAIL %s state=%0d expected=%0d", tag, state, es);
        end
        tests++;
        assert (running === (es == 2'd1)) else begin
            fails++;
            $error("FAIL %s running=%b expected=%b", tag, running, (es == 2'd1));
        end
        tests++;
        assert (alarm === (es == 2'd3)) else begin
            fails++;
            $error("FAIL %s alarm=%b expected=%b", tag, alarm, (es == 2'd3));
        end
    endtask

    initial begin
        reset_p = 1'b1;
        btn_clear = 1'b0; btn_start = 1'b0; tick_1s = 1'b0; btn_min_inc = 1'b0; btn_sec_inc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 16'h0000, 2'd0);
        @(negedge clk);
        reset_p = 1'b0;

        // Load 01:30, tick ignored in IDLE
        repeat_step(1, 1'b0, 1'b1, 1'b0);
        repeat_step(30, 1'b0, 1'b0, 1'b1);
        chk("load_0130", 16'h0130, 2'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("idle_tick", 16'h0130, 2'd0);

        // Full countdown to alarm
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("start", 16'h0130, 2'd1);
        repeat_step(1, 1'b1, 1'b0, 1'b0);
        chk("tick1", 16'h0129, 2'd1);
        repeat_step(30, 1'b1, 1'b0, 1'b0);
        chk("tick31", 16'h0059, 2'd1);
        repeat_step(58, 1'b1, 1'b0, 1'b0);
        chk("tick89", 16'h0001, 2'd1);
        repeat_step(1, 1'b1, 1'b0, 1'b0);
        chk("tick90_alarm", 16'h0000, 2'd3);

        // Alarm times out after 3 ticks; inc ignored during alarm
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("alarm_inc_ign", 16'h0000, 2'd3);
        repeat_step(2, 1'b1, 1'b0, 1'b0);
        chk("alarm_2ticks", 16'h0000, 2'd3);
        repeat_step(1, 1'b1, 1'b0, 1'b0);
        chk("alarm_timeout", 16'h0000, 2'd0);

        // Borrow chain 10:00 -> 09:59
        repeat_step(10, 1'b0, 1'b1, 1'b0);
        chk("load_1000", 16'h1000, 2'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("borrow_0959", 16'h0959, 2'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clear_run", 16'h0000, 2'd0);

        // Seconds and minutes wraps
        repeat_step(59, 1'b0, 1'b0, 1'b1);
        repeat_step(3, 1'b0, 1'b1, 1'b0);
        chk("load_0359", 16'h0359, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sec_wrap", 16'h0300, 2'd0);
        repeat_step(96, 1'b0, 1'b1, 1'b0);
        chk("min_99", 16'h9900, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("min_wrap", 16'h0000, 2'd0);

        // Start at zero ignored; pause behaviour
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_zero", 16'h0000, 2'd0);
        repeat_step(5, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat_step(2, 1'b1, 1'b0, 1'b0);
        chk("run_0003", 16'h0003, 2'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat_step(3, 1'b1, 1'b0, 1'b0);
        chk("pause_frozen", 16'h0003, 2'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("pause_inc_ign", 16'h0003, 2'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("resume", 16'h0003, 2'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("start_tick_same", 16'h0003, 2'd2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clear_pause", 16'h0000, 2'd0);

        // Alarm acknowledged by start
        repeat_step(2, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat_step(2, 1'b1, 1'b0, 1'b0);
        chk("alarm_again", 16'h0000, 2'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("alarm_ack", 16'h0000, 2'd0);

        // Clear beats start in RUN
        repeat_step(7, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("clear_prio", 16'h0000, 2'd0);

        // Asynchronous reset mid-RUN at 00:42
        repeat_step(42, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("run_0042", 16'h0042, 2'd1);
        #2;
        reset_p = 1'b1;
        #1;
        chk("async_reset", 16'h0000, 2'd0);
        @(negedge clk);
        reset_p = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_reset", 16'h0100, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
